axil_console_slv: RTL and testbench

- Synthesizable AXI4-Lite responder for the console window at BASE_ADDR; completes CPU write/read handshakes that the simulation print monitor only observes.
- Bytes written to TXDATA enter a TX FIFO and drain onto a valid/ready byte stream toward a UART or host bridge.
- Sits on the CPU data bus beside main memory.

---
 rtl/axil_console_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/axil_console_slv.sv | 216 +++++++++++++++++++++
 tb/tb_axil_console_slv.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_console_pkg.sv
// Shared definitions for the AXI4-Lite console slave.
// Holds the register offsets, the AXI response codes and the state types
// of the write and read channel FSMs.
package axil_console_pkg;

  localparam logic [3:0] OFS_TXDATA  = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push/push_data  write side; full reports no free slot
//   pop/head_data   read side; head_data is the oldest entry, empty when none
//   level           number of stored entries (0..DEPTH)
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (level == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rptr];

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axil_console_slv.sv
// AXI4-Lite console slave: a 16-byte window at BASE_ADDR with TXDATA (0x0)
// feeding a byte FIFO and a read-only STATUS word (0x4) reporting
// full (bit0), empty (bit1) and level (bits 8 and up). Other offsets and
// addresses outside the window answer SLVERR.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*      AXI4-Lite write address, data and response channels
//   s_ar*/s_r*           AXI4-Lite read address and data channels
//   tx_valid/tx_ready    byte stream out of the FIFO, tx_data is the head
//   tx_level             FIFO occupancy
module axil_console_slv
  import axil_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [31:0]      s_awaddr,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [31:0]      s_wdata,
  input  logic [3:0]       s_wstrb,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [1:0]       s_bresp,
  input  logic             s_arvalid,
  output logic             s_arready,
  input  logic [31:0]      s_araddr,
  output logic             s_rvalid,
  input  logic             s_rready,
  output logic [31:0]      s_rdata,
  output logic [1:0]       s_rresp,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [LVL_W-1:0] tx_level
);

  wr_state_t  w_state, w_next;
  rd_state_t  r_state, r_next;

  logic        aw_held, w_held, aw_held_d, w_held_d;
  logic        awready_q, wready_q, awready_d, wready_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:2] awaddr_q;
  logic [7:0]  wbyte_q;
  logic        wstrb0_q;

  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  wr_ofs, rd_ofs;
  logic        wr_hit, rd_hit;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0] status_word;
  logic        unused_ok;

  // Only the low byte, strobe 0 and word-aligned address bits matter here.
  assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata[31:8], s_wstrb[3:1]};

  assign aw_hs = s_awvalid && awready_q;
  assign w_hs  = s_wvalid && wready_q;
  assign ar_hs = s_arvalid && arready_q;

  assign wr_ofs = {awaddr_q[3:2], 2'b00};
  assign rd_ofs = {s_araddr[3:2], 2'b00};
  assign wr_hit = (awaddr_q[31:4] == BASE_ADDR[31:4]) &&
                  (wr_ofs == OFS_TXDATA || wr_ofs == OFS_STATUS);
  assign rd_hit = (s_araddr[31:4] == BASE_ADDR[31:4]) &&
                  (rd_ofs == OFS_TXDATA || rd_ofs == OFS_STATUS);

  assign fifo_pop = tx_ready && !fifo_empty;

  always_comb begin
    status_word                = '0;
    status_word[0]             = fifo_full;
    status_word[1]             = fifo_empty;
    status_word[8 +: LVL_W]    = fifo_level;
  end

  always_comb begin
    w_next    = w_state;
    aw_held_d = aw_held || aw_hs;
    w_held_d  = w_held || w_hs;
    bresp_d   = bresp_q;
    fifo_push = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_held_d && w_held_d) w_next = W_EXEC;
      end
      W_EXEC: begin
        if (!wr_hit) begin
          bresp_d = RESP_SLVERR;
          w_next  = W_RESP;
        end else if (wr_ofs == OFS_TXDATA && wstrb0_q) begin
          // Stall without a response while full; a same-cycle pop frees a slot.
          if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            bresp_d   = RESP_OKAY;
            w_next    = W_RESP;
          end
        end else begin
          bresp_d = RESP_OKAY;
          w_next  = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_next    = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
    awready_d = (w_next == W_IDLE) && !aw_held_d;
    wready_d  = (w_next == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_next;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= s_awaddr[31:2];
    if (w_hs) begin
      wbyte_q  <= s_wdata[7:0];
      wstrb0_q <= s_wstrb[0];
    end
  end

  // Read data is captured from pre-edge FIFO state at the AR handshake.
  always_comb begin
    r_next  = r_state;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_next = R_DATA;
          if (!rd_hit) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = (rd_ofs == OFS_STATUS) ? status_word : '0;
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_DATA: begin
        if (s_rready) r_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (fifo_push),
    .push_data (wbyte_q),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .head_data (tx_data),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign tx_valid  = !fifo_empty;
  assign tx_level  = fifo_level;

endmodule

// File: tb/tb_axil_console_slv.sv
module tb_axil_console_slv;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          DEPTH  = 8;
  localparam int          LVL_W  = 4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic clk = 1'b0;
  logic resetn;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [LVL_W-1:0] tx_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  axil_console_slv #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_level(tx_level)
  );

  // Every byte the consumer accepts, in order.
  always @(negedge clk) begin
    if (resetn && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // STATUS word as the register map defines it, from an occupancy count.
  function automatic logic [31:0] status_exp(input int lvl);
    logic [31:0] w;
    w = 32'(lvl) << 8;
    if (lvl == 0)     w = w | 32'h2;
    if (lvl == DEPTH) w = w | 32'h1;
    return w;
  endfunction

  function automatic logic [31:0] rand_unmapped();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a = {BASE[31:4], 1'b1, a[2:0]};
    else if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
    return a;
  endfunction

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aws, input int ws, output bit ok);
    bit awd, wd;
    int cyc;
    awd = 0; wd = 0; cyc = 0; ok = 1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while (!(awd && wd)) begin
      s_awvalid = !awd && (cyc >= aws);
      s_wvalid  = !wd && (cyc >= ws);
      @(negedge clk);
      if (s_awvalid && s_awready) awd = 1;
      if (s_wvalid && s_wready)   wd  = 1;
      tick();
      cyc++;
      if (cyc > 40) begin ok = 0; break; end
    end
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output bit ok);
    ok = 0; resp = 2'b11; s_bready = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s_bvalid) begin resp = s_bresp; ok = 1; end
      tick();
      if (ok) break;
    end
    s_bready = 0;
  endtask

  task automatic send_ar(input logic [31:0] addr, output bit ok);
    ok = 0; s_araddr = addr; s_arvalid = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s_arready) ok = 1;
      tick();
      if (ok) break;
    end
    s_arvalid = 0;
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
    ok = 0; lat = 0; data = 32'hDEAD_BEEF; resp = 2'b11; s_rready = 1;
    for (int n = 0; n < 40; n++) begin
      lat++;
      @(negedge clk);
      if (s_rvalid) begin data = s_rdata; resp = s_rresp; ok = 1; end
      tick();
      if (ok) break;
    end
    s_rready = 0;
  endtask

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aws, input int ws, input logic [1:0] eresp);
    bit ok;
    logic [1:0] r;
    send_aw_w(addr, data, strb, aws, ws, ok);
    chk({nm, "_aw_w_timeout"}, 32'(ok), 32'd1);
    if (ok) begin
      wait_b(r, ok);
      chk({nm, "_b_timeout"}, 32'(ok), 32'd1);
      chk({nm, "_bresp"}, 32'(r), 32'(eresp));
    end
  endtask

  task automatic do_read(input string nm, input logic [31:0] addr, input logic [31:0] edata,
                         input logic [1:0] eresp);
    bit ok;
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    send_ar(addr, ok);
    chk({nm, "_ar_timeout"}, 32'(ok), 32'd1);
    if (ok) begin
      wait_r(d, r, lat, ok);
      chk({nm, "_r_timeout"}, 32'(ok), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'd1);
      chk({nm, "_rdata"}, d, edata);
      chk({nm, "_rresp"}, 32'(r), 32'(eresp));
    end
  endtask

  // Match every accepted byte against the oldest expected one.
  task automatic check_got();
    logic [7:0] b;
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(b), 32'hFFFF_FFFF);
      else chk("tx_order", 32'(b), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drain_all();
    bit done;
    done = 0;
    tx_ready = 1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (tx_level == '0) done = 1;
      tick();
    end
    tx_ready = 0;
    chk("drain_timeout", 32'(done), 32'd1);
    check_got();
    chk("tx_missing_bytes", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lvl;
  } vec_t;

  vec_t tbl[14];
  bit ok, got_b;
  logic [1:0] r2;
  logic [7:0] b;
  logic [3:0] st;
  int op, k;

  initial begin
    tbl[0]  = '{0, BASE + 32'h0,  32'h0000_AB55, 4'h1, OKAY,   32'h0,   1};
    tbl[1]  = '{0, BASE + 32'h0,  32'h0000_0066, 4'hE, OKAY,   32'h0,   1};
    tbl[2]  = '{0, BASE + 32'h4,  32'h0000_0099, 4'hF, OKAY,   32'h0,   1};
    tbl[3]  = '{0, BASE + 32'h8,  32'h0000_0011, 4'h1, SLVERR, 32'h0,   1};
    tbl[4]  = '{0, BASE + 32'hC,  32'h0000_0022, 4'h1, SLVERR, 32'h0,   1};
    tbl[5]  = '{0, BASE + 32'h10, 32'h0000_0012, 4'h1, SLVERR, 32'h0,   1};
    tbl[6]  = '{1, BASE + 32'h0,  32'h0,         4'h0, OKAY,   32'h0,   1};
    tbl[7]  = '{1, BASE + 32'h4,  32'h0,         4'h0, OKAY,   32'h100, 1};
    tbl[8]  = '{1, BASE + 32'h8,  32'h0,         4'h0, SLVERR, 32'h0,   1};
    tbl[9]  = '{1, 32'h2000_0000, 32'h0,         4'h0, SLVERR, 32'h0,   1};
    tbl[10] = '{0, BASE + 32'h2,  32'h0000_0077, 4'h1, OKAY,   32'h0,   2};
    tbl[11] = '{1, BASE + 32'h7,  32'h0,         4'h0, OKAY,   32'h200, 2};
    tbl[12] = '{0, 32'h0000_0000, 32'h0000_0033, 4'h1, SLVERR, 32'h0,   2};
    tbl[13] = '{1, BASE - 32'h4,  32'h0,         4'h0, SLVERR, 32'h0,   2};

    resetn = 0; tx_ready = 0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready",  32'(s_wready),  32'd0);
    chk("rst_bvalid",  32'(s_bvalid),  32'd0);
    chk("rst_bresp",   32'(s_bresp),   32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_rvalid",  32'(s_rvalid),  32'd0);
    chk("rst_rdata",   s_rdata,        32'd0);
    chk("rst_rresp",   32'(s_rresp),   32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    tick();
    resetn = 1;
    tick();

    // Single byte, AW one cycle ahead of W, consumer ready.
    tx_ready = 1;
    send_aw_w(BASE, 32'h41, 4'h1, 0, 1, ok);
    chk("t1_aw_w_timeout", 32'(ok), 32'd1);
    got_b = 0;
    for (int n = 0; n < 20 && !got_b; n++) begin
      @(negedge clk);
      if (s_bvalid) begin
        got_b = 1;
        chk("t1_tx_valid", 32'(tx_valid), 32'd1);
        chk("t1_tx_data",  32'(tx_data),  32'h41);
        chk("t1_bresp",    32'(s_bresp),  32'(OKAY));
      end else tick();
    end
    chk("t1_b_timeout", 32'(got_b), 32'd1);
    tick();
    s_bready = 1;
    @(negedge clk);
    chk("t1_bvalid_held", 32'(s_bvalid), 32'd1);
    tick();
    s_bready = 0;
    @(negedge clk);
    chk("t1_level_back_0", 32'(tx_level), 32'd0);
    chk("t1_bvalid_done",  32'(s_bvalid), 32'd0);
    tick();
    tx_ready = 0;
    exp_q.push_back(8'h41);
    check_got();

    // Register map vectors, consumer stalled.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rd) do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rdata, tbl[i].resp);
      else do_write($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, tbl[i].resp);
      chk($sformatf("vec%0d_level", i), 32'(tx_level), 32'(tbl[i].lvl));
    end
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h77);
    drain_all();

    // Fill to full, ninth write stalls with no response until a pop.
    for (int i = 0; i < DEPTH; i++) begin
      do_write($sformatf("fill%0d", i), BASE, 32'h30 + 32'(i), 4'h1, i % 3, (i + 1) % 3, OKAY);
      exp_q.push_back(8'h30 + 8'(i));
    end
    chk("full_level", 32'(tx_level), 32'(DEPTH));
    do_read("full_status", BASE + 32'h4, status_exp(DEPTH), OKAY);
    send_aw_w(BASE, 32'h38, 4'h1, 0, 0, ok);
    chk("full9_aw_w_timeout", 32'(ok), 32'd1);
    s_bready = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("full9_bvalid_held_low", 32'(s_bvalid), 32'd0);
      tick();
    end
    tx_ready = 1;
    wait_b(r2, ok);
    chk("full9_b_timeout", 32'(ok), 32'd1);
    chk("full9_bresp", 32'(r2), 32'(OKAY));
    exp_q.push_back(8'h38);
    drain_all();

    // STATUS with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      do_write("q3", BASE, 32'h61 + 32'(i), 4'hF, 1, 0, OKAY);
      exp_q.push_back(8'h61 + 8'(i));
    end
    do_read("status3", BASE + 32'h4, status_exp(3), OKAY);

    // Both responses held by the master; further requests must not be taken.
    send_aw_w(BASE + 32'hC, 32'h5A, 4'h1, 0, 0, ok);
    chk("hold_aw_w_timeout", 32'(ok), 32'd1);
    send_ar(BASE + 32'h4, ok);
    chk("hold_ar_timeout", 32'(ok), 32'd1);
    s_awaddr = BASE; s_awvalid = 1; s_araddr = BASE; s_arvalid = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("hold_bvalid",  32'(s_bvalid),  32'd1);
      chk("hold_bresp",   32'(s_bresp),   32'(SLVERR));
      chk("hold_rvalid",  32'(s_rvalid),  32'd1);
      chk("hold_rdata",   s_rdata,        status_exp(3));
      chk("hold_awready", 32'(s_awready), 32'd0);
      chk("hold_arready", 32'(s_arready), 32'd0);
      tick();
    end
    s_awvalid = 0; s_arvalid = 0;
    wait_b(r2, ok);
    chk("hold_bresp_final", 32'(r2), 32'(SLVERR));
    begin
      logic [31:0] d; logic [1:0] rr; int lat;
      wait_r(d, rr, lat, ok);
      chk("hold_r_timeout", 32'(ok), 32'd1);
      chk("hold_rdata_final", d, status_exp(3));
      chk("hold_rresp_final", 32'(rr), 32'(OKAY));
    end
    chk("hold_level_untouched", 32'(tx_level), 32'd3);
    drain_all();

    // Reset while a write response is pending with two bytes queued.
    do_write("rst_pre", BASE, 32'h71, 4'h1, 0, 0, OKAY);
    send_aw_w(BASE, 32'h72, 4'h1, 0, 0, ok);
    chk("rst_aw_w_timeout", 32'(ok), 32'd1);
    got_b = 0;
    for (int n = 0; n < 20 && !got_b; n++) begin
      @(negedge clk);
      if (s_bvalid) got_b = 1;
      tick();
    end
    chk("rst_reach_wresp", 32'(got_b), 32'd1);
    chk("rst_level_before", 32'(tx_level), 32'd2);
    resetn = 0;
    @(negedge clk);
    chk("rst_mid_bvalid",   32'(s_bvalid), 32'd0);
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_tx_level", 32'(tx_level), 32'd0);
    tick();
    resetn = 1;
    exp_q.delete();
    got_q.delete();
    tick();

    // Random traffic against a queue model of the FIFO.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          b  = 8'($urandom);
          st = 4'($urandom);
          if (exp_q.size() == DEPTH) st[0] = 1'b0;
          do_write("rnd_tx", BASE + 32'($urandom_range(0, 3)), {24'($urandom), b}, st,
                   $urandom_range(0, 2), $urandom_range(0, 2), OKAY);
          if (st[0]) exp_q.push_back(b);
          chk("rnd_tx_level", 32'(tx_level), 32'(exp_q.size()));
        end
        2: do_read("rnd_status", BASE + 32'h4, status_exp(exp_q.size()), OKAY);
        3: begin
          do_write("rnd_bad_wr", rand_unmapped(), $urandom, 4'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), SLVERR);
          chk("rnd_bad_wr_level", 32'(tx_level), 32'(exp_q.size()));
        end
        4: do_read("rnd_bad_rd", rand_unmapped(), 32'h0, SLVERR);
        default: begin
          k = $urandom_range(1, 4);
          tx_ready = 1;
          repeat (k) tick();
          tx_ready = 0;
          check_got();
          @(negedge clk);
          chk("rnd_drain_level", 32'(tx_level), 32'(exp_q.size()));
          tick();
        end
      endcase
    end
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
